// File: rtl/codec_stream_ctrl.sv
// Pairs bytes from two streams into a GF(2^8) codec, tags results through its LATENCY-deep pipe and buffers them.
// In->out latency LATENCY+1 cycles; inputs stall on credit (FIFO fill + in-flight) so output backpressure never drops data.
module codec_stream_ctrl #(
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [7:0]       iCoef1,
  input  logic [7:0]       iCoef2,
  input  logic [LEN_W-1:0] iLength,
  output logic             oBusy,
  output logic             oDone,
  input  logic             iIn1Valid,
  input  logic [7:0]       iIn1Data,
  output logic             oIn1Ready,
  input  logic             iIn2Valid,
  input  logic [7:0]       iIn2Data,
  output logic             oIn2Ready,
  output logic [7:0]       oCodecCoef1,
  output logic [7:0]       oCodecIn1,
  output logic [7:0]       oCodecCoef2,
  output logic [7:0]       oCodecIn2,
  input  logic [7:0]       iCodecOut,
  output logic             oOutValid,
  output logic [7:0]       oOutData,
  output logic             oOutLast,
  input  logic             iOutReady
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q;
  logic [7:0]         coef1_q, coef1_d, coef2_q, coef2_d;
  logic [7:0]         in1_q, in1_d, in2_q, in2_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] lastm_q, lastm_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic [OCC_W-1:0]   inflight, occupancy;
  logic               credit_ok, fire, last_fire, start_acc, push, pop, fifo_nonempty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + OCC_W'(tag_vld_q[i]);
    end
    occupancy     = OCC_W'(fifo_cnt_q) + inflight;
    credit_ok     = occupancy < OCC_W'(FIFO_DEPTH);
    fire          = (state_q == S_RUN) && credit_ok && iIn1Valid && iIn2Valid;
    last_fire     = fire && (remaining_q == LEN_W'(1));
    start_acc     = (state_q == S_IDLE) && iStart;
    fifo_nonempty = fifo_cnt_q != '0;
    push          = tag_vld_q[LATENCY-1];
    pop           = fifo_nonempty && iOutReady;
  end

  assign oIn1Ready   = (state_q == S_RUN) && credit_ok && iIn2Valid;
  assign oIn2Ready   = (state_q == S_RUN) && credit_ok && iIn1Valid;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oCodecCoef1 = coef1_q;
  assign oCodecCoef2 = coef2_q;
  assign oCodecIn1   = in1_q;
  assign oCodecIn2   = in2_q;
  assign oOutValid   = fifo_nonempty;
  assign oOutData    = mem_q[rd_ptr_q];
  assign oOutLast    = fifo_nonempty && lastm_q[rd_ptr_q];

  always_comb begin
    coef1_d     = start_acc ? iCoef1 : coef1_q;
    coef2_d     = start_acc ? iCoef2 : coef2_q;
    in1_d       = fire ? iIn1Data : in1_q;
    in2_d       = fire ? iIn2Data : in2_q;
    remaining_d = remaining_q;
    if (start_acc) begin
      remaining_d = iLength;
    end else if (fire) begin
      remaining_d = remaining_q - LEN_W'(1);
    end
    // Tag pipe mirrors the codec pipeline so the result and its last flag arrive together.
    tag_vld_d     = '0;
    tag_last_d    = '0;
    tag_vld_d[0]  = fire;
    tag_last_d[0] = last_fire;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end
  end

  always_comb begin
    mem_d      = mem_q;
    lastm_d    = lastm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q]   = iCodecOut;
      lastm_d[wr_ptr_q] = tag_last_q[LATENCY-1];
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      coef1_q     <= '0;
      coef2_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      remaining_q <= '0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      mem_q       <= '{default: '0};
      lastm_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      coef1_q     <= coef1_d;
      coef2_q     <= coef2_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      remaining_q <= remaining_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      mem_q       <= mem_d;
      lastm_q     <= lastm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart && (iLength != '0)) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else if (iStart) begin
            state_q <= S_DONE;
            busy_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (last_fire) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && !fifo_nonempty) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Credit accounting makes a push into a full, non-popping FIFO unreachable.
  assert property (@(posedge iCLK) disable iff (!iRST_n)
                   !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_codec_stream_ctrl.sv
// Directed bench for codec_stream_ctrl with a behavioural GF(2^8) codec (LATENCY=1) closing the loop.
module tb_codec_stream_ctrl;

  logic        clk, rst_n;
  logic        start;
  logic [7:0]  coef1, coef2;
  logic [15:0] len;
  logic        busy, done;
  logic        in1_v, in2_v, in1_r, in2_r;
  logic [7:0]  d1, d2;
  logic [7:0]  c_coef1, c_in1, c_coef2, c_in2, codec_out;
  logic        out_v, out_last, out_r;
  logic [7:0]  out_d;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int valid_seen = 0;
  int acc;
  int n;
  logic [8:0] outq [$];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  assign codec_out = gf_mul(c_coef1, c_in1) ^ gf_mul(c_coef2, c_in2);

  codec_stream_ctrl #(.LATENCY(1), .FIFO_DEPTH(4), .LEN_W(16)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start), .iCoef1(coef1), .iCoef2(coef2),
    .iLength(len), .oBusy(busy), .oDone(done),
    .iIn1Valid(in1_v), .iIn1Data(d1), .oIn1Ready(in1_r),
    .iIn2Valid(in2_v), .iIn2Data(d2), .oIn2Ready(in2_r),
    .oCodecCoef1(c_coef1), .oCodecIn1(c_in1), .oCodecCoef2(c_coef2), .oCodecIn2(c_in2),
    .iCodecOut(codec_out), .oOutValid(out_v), .oOutData(out_d), .oOutLast(out_last),
    .iOutReady(out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_v && out_r) outq.push_back({out_last, out_d});
      if (done) done_pulses++;
      if (out_v) valid_seen = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_packet(input logic [7:0] c1, input logic [7:0] c2, input logic [15:0] l);
    outq.delete();
    done_pulses = 0;
    valid_seen  = 0;
    coef1 = c1; coef2 = c2; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    in1_v = 1'b1; in2_v = 1'b1; d1 = a; d2 = b;
    #1;
    while (!in1_r && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) begin
      checks++;
      failures++;
      $error("FAIL pair_timeout observed=stalled expected=accept");
    end
    tick();
    in1_v = 1'b0; in2_v = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_pulses == 0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check("done_pulse_count", done_pulses, 1);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; coef1 = '0; coef2 = '0; len = '0;
    in1_v = 1'b1; in2_v = 1'b1; d1 = 8'h11; d2 = 8'h22; out_r = 1'b1;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in1_ready", in1_r, 1'b0);
    check("rst_out_valid", out_v, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_codec_coef1", c_coef1, 8'h00);
    check("rst_codec_in1", c_in1, 8'h00);
    in1_v = 1'b0; in2_v = 1'b0;
    #6 rst_n = 1'b1;
    tick();

    // T1: identity on stream 1
    begin_packet(8'h01, 8'h00, 16'd4);
    check("t1_busy", busy, 1'b1);
    check("t1_coef1", c_coef1, 8'h01);
    for (int i = 1; i <= 4; i++) push_pair(8'(i), 8'hAA);
    wait_done();
    check("t1_count", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      check("t1_data", outq[i][7:0], 8'(i + 1));
      check("t1_last", outq[i][8], (i == 3) ? 1'b1 : 1'b0);
    end

    // T2: 02*80 ^ 03*01 = 1B ^ 03 = 18, latency check
    begin_packet(8'h02, 8'h03, 16'd1);
    in1_v = 1'b1; in2_v = 1'b1; d1 = 8'h80; d2 = 8'h01;
    #1;
    check("t2_ready", in1_r, 1'b1);
    tick();
    in1_v = 1'b0; in2_v = 1'b0;
    check("t2_codec_in1", c_in1, 8'h80);
    check("t2_codec_in2", c_in2, 8'h01);
    check("t2_not_yet_valid", out_v, 1'b0);
    tick();
    check("t2_valid", out_v, 1'b1);
    check("t2_data", out_d, 8'h18);
    check("t2_last", out_last, 1'b1);
    wait_done();
    check("t2_count", outq.size(), 1);

    // T3: egress blocked, credit limits acceptance to FIFO_DEPTH pairs
    begin_packet(8'h03, 8'h05, 16'd16);
    out_r = 1'b0;
    acc = 0;
    in1_v = 1'b1; in2_v = 1'b1;
    repeat (20) begin
      d1 = 8'(acc); d2 = 8'(acc + 8'h40);
      #1;
      if (in1_r) acc++;
      tick();
    end
    check("t3_accepted_blocked", acc, 4);
    check("t3_ready_low", in1_r, 1'b0);
    check("t3_head_valid", out_v, 1'b1);
    check("t3_head_data", out_d, gf_mul(8'h03, 8'h00) ^ gf_mul(8'h05, 8'h40));
    out_r = 1'b1;
    n = 0;
    while (acc < 16 && n < 200) begin
      d1 = 8'(acc); d2 = 8'(acc + 8'h40);
      #1;
      if (in1_r) acc++;
      tick();
      n++;
    end
    in1_v = 1'b0; in2_v = 1'b0;
    check("t3_accepted_total", acc, 16);
    wait_done();
    check("t3_count", outq.size(), 16);
    for (int i = 0; i < 16 && i < outq.size(); i++) begin
      check("t3_data", outq[i][7:0], gf_mul(8'h03, 8'(i)) ^ gf_mul(8'h05, 8'(i + 8'h40)));
      check("t3_last", outq[i][8], (i == 15) ? 1'b1 : 1'b0);
    end

    // T4: zero-length packet
    begin_packet(8'h07, 8'h09, 16'd0);
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b1);
    tick();
    check("t4_done_low", done, 1'b0);
    check("t4_idle", busy, 1'b0);
    repeat (3) tick();
    check("t4_no_valid", valid_seen, 0);
    check("t4_one_done", done_pulses, 1);

    // T5: stream 2 absent holds off the pair
    begin_packet(8'h01, 8'h01, 16'd1);
    in1_v = 1'b1; in2_v = 1'b0; d1 = 8'h05; d2 = 8'h03;
    #1;
    check("t5_in1_ready_low", in1_r, 1'b0);
    check("t5_in2_ready_high", in2_r, 1'b1);
    repeat (5) tick();
    check("t5_operand_held", c_in1, 8'h0F);
    check("t5_still_run", busy, 1'b1);
    check("t5_no_valid", out_v, 1'b0);
    in2_v = 1'b1;
    #1;
    check("t5_in1_ready", in1_r, 1'b1);
    tick();
    in1_v = 1'b0; in2_v = 1'b0;
    check("t5_fired", c_in1, 8'h05);
    wait_done();
    check("t5_count", outq.size(), 1);
    if (outq.size() > 0) check("t5_entry", outq[0], {1'b1, 8'h06});

    // T6: reset mid-packet, then a clean packet
    begin_packet(8'h01, 8'h00, 16'd8);
    for (int i = 1; i <= 3; i++) push_pair(8'(i), 8'h00);
    in1_v = 1'b1; in2_v = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", out_v, 1'b0);
    check("t6_rst_last", out_last, 1'b0);
    check("t6_rst_ready", in1_r, 1'b0);
    check("t6_rst_codec_in1", c_in1, 8'h00);
    check("t6_rst_coef1", c_coef1, 8'h00);
    check("t6_no_done", done_pulses, 0);
    n = 0;
    foreach (outq[i]) if (outq[i][8]) n++;
    check("t6_no_last", n, 0);
    in1_v = 1'b0; in2_v = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    begin_packet(8'h02, 8'h00, 16'd2);
    push_pair(8'h01, 8'h55);
    push_pair(8'h02, 8'h55);
    wait_done();
    check("t6_count", outq.size(), 2);
    if (outq.size() == 2) begin
      check("t6_entry0", outq[0], {1'b0, 8'h02});
      check("t6_entry1", outq[1], {1'b1, 8'h04});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
